// File: rtl/instr_sequencer_if.sv
// ----------------------------------------------------------------------------
// instr_sequencer_if
//   Bundles every non-clock/reset signal of the VR16 instruction sequencer:
//   the imem fetch handshake, the ALU start/done handshake, the register-file
//   write handshake, and the status outputs.
//
//   master : the sequencer (drives requests and status, receives responses)
//   slave  : the surrounding datapath / memory / control environment
//
//   run           env -> seq   resume pulse, honoured only while halted
//   imem_req      seq -> env   fetch request
//   imem_addr     seq -> env   fetch address (= pc)
//   imem_valid    env -> seq   imem_data valid
//   imem_data     env -> seq   instruction word, opcode in [15:12]
//   alu_enable    seq -> env   one-cycle ALU start pulse
//   rf_raddr_a/b  seq -> env   ADD source register addresses
//   alu_done      env -> seq   alu_result valid
//   alu_result    env -> seq   ALU result
//   rf_we         seq -> env   register write request, held until write_done
//   rf_waddr      seq -> env   destination register
//   rf_wdata      seq -> env   write data
//   write_done    env -> seq   register file accepted the write
//   flag_output   seq -> env   class of last decoded instruction
//   pc            seq -> env   current PC
//   halted        seq -> env   sequencer is halted
//   fault         seq -> env   sticky ALU-timeout fault
//   illegal_op    seq -> env   one-cycle pulse on undefined opcode
//   retire_count  seq -> env   retired instruction count
// ----------------------------------------------------------------------------
interface instr_sequencer_if;
    logic        run;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        alu_enable;
    logic [1:0]  rf_raddr_a;
    logic [1:0]  rf_raddr_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        write_done;
    logic [1:0]  flag_output;
    logic [11:0] pc;
    logic        halted;
    logic        fault;
    logic        illegal_op;
    logic [15:0] retire_count;

    modport master (
        input  run, imem_valid, imem_data, alu_done, alu_result, write_done,
        output imem_req, imem_addr, alu_enable, rf_raddr_a, rf_raddr_b,
               rf_we, rf_waddr, rf_wdata, flag_output, pc, halted, fault,
               illegal_op, retire_count
    );

    modport slave (
        output run, imem_valid, imem_data, alu_done, alu_result, write_done,
        input  imem_req, imem_addr, alu_enable, rf_raddr_a, rf_raddr_b,
               rf_we, rf_waddr, rf_wdata, flag_output, pc, halted, fault,
               illegal_op, retire_count
    );
endinterface

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle fetch/decode/execute scheduler for the VR16 core. Owns the
//   12-bit PC and the instruction register and sequences imem, the ALU and
//   the register-file write port for ADD, STOREI, JUMP, DELETE and HALT.
//
//   Parameters
//     RESET_PC     PC value loaded on reset
//     ALU_TIMEOUT  max EXEC cycles waiting for alu_done before faulting (>=2)
//
//   Ports
//     i_clk    rising-edge clock
//     i_reset  synchronous active-high reset; wins over every other event
//     bus      instr_sequencer_if.master (fetch, ALU, register-file write
//              handshakes and status outputs)
// ----------------------------------------------------------------------------
module instr_sequencer #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter int unsigned ALU_TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    instr_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_STOREI = 4'b1000;
    localparam logic [3:0] OP_JUMP   = 4'b1001;
    localparam logic [3:0] OP_DELETE = 4'b1010;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    // Value of the EXEC timer on the last cycle alu_done is still accepted.
    localparam logic [15:0] EXEC_LAST = 16'(ALU_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_wdata;
    logic [1:0]  r_flag;
    logic        r_fault;
    logic [15:0] r_retire;
    logic [15:0] r_exec_cnt;

    logic        w_ir_load;
    logic        w_pc_inc;
    logic        w_pc_jump;
    logic        w_wdata_load;
    logic [15:0] w_wdata_val;
    logic        w_flag_load;
    logic [1:0]  w_flag_val;
    logic        w_fault_set;
    logic        w_retire;
    logic        w_cnt_inc;
    logic        w_illegal;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ir_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_jump    = 1'b0;
        w_wdata_load = 1'b0;
        w_wdata_val  = '0;
        w_flag_load  = 1'b0;
        w_flag_val   = r_flag;
        w_fault_set  = 1'b0;
        w_retire     = 1'b0;
        w_cnt_inc    = 1'b0;
        w_illegal    = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                if (bus.imem_valid) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                case (r_ir[15:12])
                    OP_ADD: begin
                        w_flag_load = 1'b1;
                        w_flag_val  = 2'b00;
                        w_state_nxt = S_EXEC;
                    end
                    OP_STOREI: begin
                        w_flag_load  = 1'b1;
                        w_flag_val   = 2'b00;
                        w_wdata_load = 1'b1;
                        w_wdata_val  = {8'h00, r_ir[7:0]};
                        w_state_nxt  = S_WB;
                    end
                    OP_DELETE: begin
                        w_flag_load  = 1'b1;
                        w_flag_val   = 2'b10;
                        w_wdata_load = 1'b1;
                        w_wdata_val  = 16'h0000;
                        w_state_nxt  = S_WB;
                    end
                    OP_JUMP: begin
                        w_flag_load = 1'b1;
                        w_flag_val  = 2'b01;
                        w_pc_jump   = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                    OP_HALT: begin
                        w_flag_load = 1'b1;
                        w_flag_val  = 2'b11;
                        w_retire    = 1'b1;
                        w_state_nxt = S_HALTED;
                    end
                    default: begin
                        // Undefined opcode: skip it, flag_output keeps the
                        // class of the last defined instruction.
                        w_illegal   = 1'b1;
                        w_pc_inc    = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                endcase
            end

            S_EXEC: begin
                // alu_done takes priority over the timeout on the last cycle.
                if (bus.alu_done) begin
                    w_wdata_load = 1'b1;
                    w_wdata_val  = bus.alu_result;
                    w_state_nxt  = S_WB;
                end else if (r_exec_cnt == EXEC_LAST) begin
                    w_fault_set = 1'b1;
                    w_state_nxt = S_HALTED;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            S_WB: begin
                if (bus.write_done) begin
                    w_pc_inc    = 1'b1;
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end

            S_HALTED: begin
                if (bus.run && !r_fault) begin
                    w_pc_inc    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_wdata    <= '0;
            r_flag     <= '0;
            r_fault    <= 1'b0;
            r_retire   <= '0;
            r_exec_cnt <= '0;
        end else begin
            if (w_ir_load) begin
                r_ir <= bus.imem_data;
            end
            if (w_pc_jump) begin
                r_pc <= r_ir[11:0];
            end else if (w_pc_inc) begin
                r_pc <= r_pc + 12'd1;
            end
            if (w_wdata_load) begin
                r_wdata <= w_wdata_val;
            end
            if (w_flag_load) begin
                r_flag <= w_flag_val;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
            if (w_retire) begin
                r_retire <= r_retire + 16'd1;
            end
            // Timer restarts from zero whenever EXEC is left or not waiting.
            r_exec_cnt <= w_cnt_inc ? r_exec_cnt + 16'd1 : '0;
        end
    end

    assign bus.imem_req     = (r_state == S_FETCH);
    assign bus.imem_addr    = r_pc;
    assign bus.alu_enable   = (r_state == S_EXEC) && (r_exec_cnt == '0);
    assign bus.rf_raddr_a   = r_ir[9:8];
    assign bus.rf_raddr_b   = r_ir[7:6];
    assign bus.rf_we        = (r_state == S_WB);
    assign bus.rf_waddr     = r_ir[11:10];
    assign bus.rf_wdata     = r_wdata;
    assign bus.flag_output  = r_flag;
    assign bus.pc           = r_pc;
    assign bus.halted       = (r_state == S_HALTED);
    assign bus.fault        = r_fault;
    assign bus.illegal_op   = w_illegal;
    assign bus.retire_count = r_retire;

endmodule
